// File: rtl/sram_bridge_pkg.sv
// Shared constants for the SRAM byte bridge: FSM state encoding, byte-lane
// select values and the controller's nominal per-operation cycle count.
package sram_bridge_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_WR_WAIT  = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Cycles the SRAM controller needs per operation (strobe + busy cycles).
    localparam int CTRL_OP_CYCLES = 3;

endpackage

// File: rtl/sram_byte_lane.sv
// Combinational byte-lane helper: extracts the selected byte from a 16-bit
// word and produces the word with that lane replaced by a new byte.
module sram_byte_lane
    import sram_bridge_pkg::*;
(
    input  logic [15:0] i_word,
    input  logic [7:0]  i_byte,
    input  logic        i_lane,
    output logic [7:0]  o_byte,
    output logic [15:0] o_word
);

    // Lane 0 is the low byte, lane 1 the high byte.
    always_comb begin
        o_byte = (i_lane == LANE_HI) ? i_word[15:8] : i_word[7:0];
        o_word = i_word;
        if (i_lane == LANE_LO) o_word[7:0]  = i_byte;
        else                   o_word[15:8] = i_byte;
    end

endmodule

// File: rtl/sram_byte_bridge.sv
// Byte-to-word bridge between the 6502 bus glue and the 16-bit SRAM
// controller. Reads return the addressed lane; writes are read-modify-write
// because the controller has no byte enables.
// Optional feature: define SRAM_BRIDGE_READ_CACHE_EN to add a one-word cache
// that short-cuts read hits and skips the read phase of write hits.
module sram_byte_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_data_write,
    input  logic [15:0]       mem_data_read,
    input  logic              mem_ready
);

    logic [2:0]      r_state;
    logic            r_seen_low;
    logic [ADDR_W:0] r_addr;
    logic            r_we;
    logic [7:0]      r_wdata;
    logic [15:0]     r_wword;
    logic [7:0]      r_rdata;

    logic            w_wait_st;
    logic            w_done;
    logic [15:0]     w_ln_word;
    logic [7:0]      w_ln_byte;
    logic            w_ln_sel;
    logic [7:0]      w_ln_out;
    logic [15:0]     w_ln_merged;

`ifdef SRAM_BRIDGE_READ_CACHE_EN
    logic              r_cv;
    logic [ADDR_W-1:0] r_ctag;
    logic [15:0]       r_cdata;
    logic              w_idle;
    logic              w_hit;

    // In IDLE the lane unit works on the cached word and the incoming request;
    // otherwise on the word returned by the controller and the captured request.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_hit     = r_cv && (r_ctag == cpu_addr[ADDR_W:1]);
    assign w_ln_word = w_idle ? r_cdata     : mem_data_read;
    assign w_ln_byte = w_idle ? cpu_wdata   : r_wdata;
    assign w_ln_sel  = w_idle ? cpu_addr[0] : r_addr[0];
`else
    assign w_ln_word = mem_data_read;
    assign w_ln_byte = r_wdata;
    assign w_ln_sel  = r_addr[0];
`endif

    sram_byte_lane u_lane (
        .i_word (w_ln_word),
        .i_byte (w_ln_byte),
        .i_lane (w_ln_sel),
        .o_byte (w_ln_out),
        .o_word (w_ln_merged)
    );

    // A wait state completes only on ready returning high after being seen low,
    // so the ready level left over from the issue cycle is never mistaken for done.
    assign w_wait_st = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
    assign w_done    = w_wait_st && r_seen_low && mem_ready;

    // Strobes fire only in the issue cycle where the controller is ready.
    assign mem_read       = (r_state == ST_RD_ISSUE) && mem_ready;
    assign mem_write      = (r_state == ST_WR_ISSUE) && mem_ready;
    assign mem_address    = r_addr[ADDR_W:1];
    assign mem_data_write = r_wword;
    assign cpu_rdata      = r_rdata;
    assign cpu_ack        = (r_state == ST_ACK);
    assign cpu_busy       = (r_state != ST_IDLE);

    // Track whether mem_ready has dropped since entering the current wait state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_seen_low <= 1'b0;
        else if (!w_wait_st) r_seen_low <= 1'b0;
        else if (w_done)     r_seen_low <= 1'b0;
        else if (!mem_ready) r_seen_low <= 1'b1;
    end

    // Main FSM with request capture, read-data/merge registers and optional cache.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wword <= '0;
            r_rdata <= '0;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
            r_cv    <= 1'b0;
            r_ctag  <= '0;
            r_cdata <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_addr  <= cpu_addr;
                        r_we    <= cpu_we;
                        r_wdata <= cpu_wdata;
`ifdef SRAM_BRIDGE_READ_CACHE_EN
                        if (w_hit && !cpu_we) begin
                            r_rdata <= w_ln_out;
                            r_state <= ST_ACK;
                        end else if (w_hit) begin
                            r_wword <= w_ln_merged;
                            r_cdata <= w_ln_merged;
                            r_state <= ST_WR_ISSUE;
                        end else begin
                            r_state <= ST_RD_ISSUE;
                        end
`else
                        r_state <= ST_RD_ISSUE;
`endif
                    end
                end
                ST_RD_ISSUE: if (mem_ready) r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (w_done) begin
                        if (r_we) begin
                            r_wword <= w_ln_merged;
                            r_state <= ST_WR_ISSUE;
                        end else begin
                            r_rdata <= w_ln_out;
                            r_state <= ST_ACK;
                        end
`ifdef SRAM_BRIDGE_READ_CACHE_EN
                        r_cv    <= 1'b1;
                        r_ctag  <= r_addr[ADDR_W:1];
                        r_cdata <= r_we ? w_ln_merged : mem_data_read;
`endif
                    end
                end
                ST_WR_ISSUE: if (mem_ready) r_state <= ST_WR_WAIT;
                ST_WR_WAIT:  if (w_done)    r_state <= ST_ACK;
                ST_ACK:      r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
